// File: rtl/inv_round_column_sequencer.sv
// inv_round_column_sequencer: AddRoundKey then column-serial InvMixColumns via external helper.
module inv_round_column_sequencer #(
   parameter int MIX_PIPE = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] state_in,
   input  logic [127:0] rkey_in,
   input  logic         skip_mix,
   output logic [31:0]  col_to_mix,
   input  logic [31:0]  col_from_mix,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] state_out,
   output logic         busy
);
   localparam int DW = (MIX_PIPE > 1) ? 2 : 1;
   typedef enum logic [1:0] {IDLE, MIX, DONE} state_t;
   state_t state_q, state_d;
   logic [3:0][31:0] buf_q, buf_d;
   logic [127:0] out_q, out_d;
   logic [1:0] i_q, i_d, j_q, j_d;
   logic iss_q, iss_d, vld_q, vld_d, cap;
   logic [DW-1:0] dly_q, dly_d;
   // Column c lives at buf_q[3-c], which is buf_q[~c] for a 2-bit index.
   assign cap = (state_q == MIX) && (dly_q == DW'(MIX_PIPE));
   always_comb begin
      state_d = state_q;
      buf_d = buf_q;
      i_d = i_q;
      j_d = j_q;
      iss_d = iss_q;
      dly_d = dly_q;
      case (state_q)
         IDLE: if (in_valid) begin
            buf_d = state_in ^ rkey_in;
            state_d = skip_mix ? DONE : MIX;
            i_d = '0;
            j_d = '0;
            iss_d = 1'b0;
            dly_d = '0;
         end
         MIX: begin
            if (!iss_q) begin
               i_d = i_q + 2'd1;
               iss_d = i_q == 2'd3;
            end
            if (!cap) dly_d = dly_q + 1'b1;
            else begin
               buf_d[~j_q] = col_from_mix;
               j_d = j_q + 2'd1;
               if (j_q == 2'd3) state_d = DONE;
            end
         end
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      vld_d = state_d == DONE;
      out_d = (state_d == DONE && state_q != DONE) ? buf_d : out_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         buf_q <= '0;
         out_q <= '0;
         i_q <= '0;
         j_q <= '0;
         iss_q <= 1'b0;
         dly_q <= '0;
         vld_q <= 1'b0;
      end else begin
         state_q <= state_d;
         buf_q <= buf_d;
         out_q <= out_d;
         i_q <= i_d;
         j_q <= j_d;
         iss_q <= iss_d;
         dly_q <= dly_d;
         vld_q <= vld_d;
      end
   end
   assign in_ready = state_q == IDLE;
   assign busy = state_q != IDLE;
   assign col_to_mix = (state_q == MIX && !iss_q) ? buf_q[~i_q] : '0;
   assign out_valid = vld_q;
   assign state_out = out_q;
endmodule

// File: tb/tb_inv_round_column_sequencer.sv
// tb_inv_round_column_sequencer: two DUTs (MIX_PIPE 0 and 2) against a latency/result model.
module tb_inv_round_column_sequencer;
   localparam logic [127:0] V1 = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
   localparam logic [127:0] R1 = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
   localparam logic [127:0] K2 = 128'h71b25e43_6023a762_fefefefe_2a2a2829;
   localparam logic [127:0] S3 = 128'h00112233_44556677_8899aabb_ccddeeff;
   localparam logic [127:0] K3 = 128'h0f0f0f0f_0f0f0f0f_0f0f0f0f_0f0f0f0f;
   localparam logic [127:0] R3 = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst = 1'b1;
   logic in_valid[2], in_ready[2], skip_mix[2], out_valid[2], out_ready[2], busy[2], hold[2];
   logic [127:0] state_in[2], rkey_in[2], state_out[2];
   logic [31:0] col_to[2], col_from[2];
   int n_chk = 0, n_pass = 0, cyc = 0, to_cnt = 0, to_seen = 0;
   int ph[2], lat[2], acc_cyc[2], pin_lat[2];
   logic skp[2], mvld[2], pinned = 1'b0;
   logic [127:0] mx[2], res[2], mout[2], pin_res[2];
   logic [31:0] ec;
   int d;

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = '0;
      for (int n = 0; n < 8; n++) begin
         if (b[n]) p ^= a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [31:0] imc(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {gm(a0, 14) ^ gm(a1, 11) ^ gm(a2, 13) ^ gm(a3, 9),
              gm(a0, 9) ^ gm(a1, 14) ^ gm(a2, 11) ^ gm(a3, 13),
              gm(a0, 13) ^ gm(a1, 9) ^ gm(a2, 14) ^ gm(a3, 11),
              gm(a0, 11) ^ gm(a1, 13) ^ gm(a2, 9) ^ gm(a3, 14)};
   endfunction

   function automatic logic [127:0] imc4(input logic [127:0] x);
      logic [127:0] r;
      for (int c = 0; c < 4; c++) r[127-32*c -: 32] = imc(x[127-32*c -: 32]);
      return r;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int P = 2 * g;
      logic [31:0] h0, h1, h2;
      assign h0 = imc(col_to[g]);
      always @(posedge clk) begin
         h1 <= h0;
         h2 <= h1;
      end
      assign col_from[g] = (P == 0) ? h0 : h2;
      inv_round_column_sequencer #(.MIX_PIPE(P)) dut (
         .clk(clk), .rst(rst), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
         .state_in(state_in[g]), .rkey_in(rkey_in[g]), .skip_mix(skip_mix[g]),
         .col_to_mix(col_to[g]), .col_from_mix(col_from[g]), .out_valid(out_valid[g]),
         .out_ready(out_ready[g]), .state_out(state_out[g]), .busy(busy[g])
      );
   end

   // Model: a transaction is just its XORed state, its result and its fixed latency.
   always @(posedge clk) begin
      cyc++;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            ph[k] = 0;
            mvld[k] = 1'b0;
            mout[k] = '0;
            skp[k] = 1'b1;
         end else if (ph[k] == 0) begin
            if (in_valid[k]) begin
               mx[k] = state_in[k] ^ rkey_in[k];
               skp[k] = skip_mix[k];
               res[k] = skp[k] ? mx[k] : imc4(mx[k]);
               lat[k] = skp[k] ? 1 : 5 + 2 * k;
               ph[k] = 1;
               acc_cyc[k] = cyc - 1;
            end
         end else if (mvld[k]) begin
            if (out_ready[k]) begin
               mvld[k] = 1'b0;
               ph[k] = 0;
            end
         end else ph[k]++;
         if (ph[k] != 0 && ph[k] == lat[k] && !mvld[k]) begin
            mvld[k] = 1'b1;
            mout[k] = res[k];
         end
      end
   end

   task automatic chk(input string nm, input int k, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s[%0d] cyc=%0d got %h expected %h", nm, k, cyc, act, exp);
   endtask

   always @(negedge clk) begin
      if (!pinned) begin
         pinned = 1'b1;
         chk("model_v1", 0, imc4(V1), R1);
         chk("model_v2", 0, imc4({4{32'hffffffff}} ^ K2), R1);
      end
      if (to_cnt != to_seen) begin
         to_seen = to_cnt;
         chk("timeout", 0, 128'(to_cnt), 128'(to_cnt - 1));
      end
      if (cyc >= 1) for (int k = 0; k < 2; k++) begin
         ec = '0;
         if (!skp[k] && ph[k] >= 1 && ph[k] <= 4) ec = mx[k][127-32*(ph[k]-1) -: 32];
         chk("in_ready", k, 128'(in_ready[k]), 128'(ph[k] == 0));
         chk("busy", k, 128'(busy[k]), 128'(ph[k] != 0));
         chk("out_valid", k, 128'(out_valid[k]), 128'(mvld[k]));
         chk("state_out", k, state_out[k], mout[k]);
         chk("col_to_mix", k, 128'(col_to[k]), 128'(ec));
         if (pin_lat[k] != 0 && ph[k] != 0) begin
            d = cyc - acc_cyc[k];
            if (d == pin_lat[k] - 1) chk("pin_early", k, 128'(out_valid[k]), 128'(0));
            if (d == pin_lat[k]) begin
               chk("pin_valid", k, 128'(out_valid[k]), 128'(1));
               chk("pin_result", k, state_out[k], pin_res[k]);
            end
         end
      end
   end

   always @(negedge clk)
      for (int k = 0; k < 2; k++) out_ready[k] = !hold[k] && ($urandom_range(0, 3) != 0);

   task automatic wait_idle(input int k);
      int n = 0;
      while (ph[k] != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) to_cnt++;
   endtask

   task automatic send(input int k, input logic [127:0] s, input logic [127:0] key, input logic sk,
                       input logic [127:0] pres, input int plat);
      wait_idle(k);
      pin_res[k] = pres;
      pin_lat[k] = plat;
      state_in[k] = s;
      rkey_in[k] = key;
      skip_mix[k] = sk;
      in_valid[k] = 1'b1;
      @(negedge clk);
      in_valid[k] = 1'b0;
      skip_mix[k] = ~sk;
      state_in[k] = rnd128();
      if (plat != 0) begin
         wait_idle(k);
         pin_lat[k] = 0;
      end
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         in_valid[k] = 1'b0;
         skip_mix[k] = 1'b0;
         state_in[k] = '0;
         rkey_in[k] = '0;
         hold[k] = 1'b0;
         pin_lat[k] = 0;
         pin_res[k] = '0;
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         send(k, V1, '0, 1'b0, R1, 5 + 2 * k);
         send(k, {4{32'hffffffff}}, K2, 1'b0, R1, 5 + 2 * k);
         send(k, S3, K3, 1'b1, R3, 1);
      end
      for (int k = 0; k < 2; k++) begin
         hold[k] = 1'b1;
         send(k, rnd128(), rnd128(), 1'b0, '0, 0);
         for (int n = 0; n < 300 && !mvld[k]; n++) @(negedge clk);
         repeat (10) begin
            @(negedge clk);
            in_valid[k] = 1'($urandom_range(0, 1));
            state_in[k] = rnd128();
            skip_mix[k] = 1'($urandom_range(0, 1));
         end
         in_valid[k] = 1'b0;
         hold[k] = 1'b0;
         send(k, V1, '0, 1'b0, R1, 5 + 2 * k);
      end
      repeat (40) begin
         send($urandom_range(0, 1), rnd128(), rnd128(), $urandom_range(0, 3) == 0, '0, 0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_idle(0);
      wait_idle(1);
      for (int k = 0; k < 2; k++) begin
         state_in[k] = rnd128();
         rkey_in[k] = rnd128();
         skip_mix[k] = 1'b0;
         in_valid[k] = 1'b1;
      end
      @(negedge clk);
      in_valid[0] = 1'b0;
      in_valid[1] = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      for (int k = 0; k < 2; k++) send(k, {4{32'hffffffff}}, K2, 1'b0, R1, 5 + 2 * k);
      wait_idle(0);
      wait_idle(1);
      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/inv_round_column_sequencer.md
Name: inv_round_column_sequencer

Overview:
- Column-serial round-tail engine for the AES-256 decryption datapath.
- Accepts a 128-bit state and a 128-bit round key, applies AddRoundKey (XOR), then streams the result one 32-bit column at a time through the external InvMixColumns column helper and reassembles the 128-bit result.
- Sits directly upstream of the column helper (feeds it, consumes its output), between InvSubBytes/InvShiftRows and the next round register.
- A skip_mix input bypasses InvMixColumns for the final decryption round.

Parameters:
- MIX_PIPE, 0, number of register stages in the external helper path. 0 means col_from_mix is valid in the same cycle as col_to_mix; N means it is valid N cycles later. Legal values 0..2.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  input state/key valid
- in_ready  out  1  block can accept input
- state_in  in  128  state; column 0 = [127:96], row 0 of each column = column[31:24]
- rkey_in  in  128  round key, same layout
- skip_mix  in  1  sampled with input; 1 = AddRoundKey only
- col_to_mix  out  32  column driven to the InvMixColumns helper
- col_from_mix  in  32  helper result column
- out_valid  out  1  state_out valid
- out_ready  in  1  downstream accepts
- state_out  out  128  result state
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - FSM goes to IDLE; out_valid=0; state_out=0; internal buffer=0; issue/capture counters=0; col_to_mix=0.
  - Reset wins over every other event. A transaction in flight is discarded and no out_valid is produced.
- FSM states: IDLE, MIX, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge T: buf <= state_in ^ rkey_in, and skip_mix is latched.
  - Next state is DONE if skip_mix=1, otherwise MIX.
- MIX:
  - Issue counter i runs 0..3, one column per cycle, starting at cycle T+1. col_to_mix = buf column i while issuing, else 0.
  - Capture counter j runs 0..3. Column j result is written into buf column j MIX_PIPE cycles after its issue.
  - Issue and capture overlap.
  - MIX lasts exactly 4+MIX_PIPE cycles, then goes to DONE.
  - A column is never overwritten before it is issued. With MIX_PIPE>0, capture j trails issue i, which is safe because j<i.
- DONE:
  - out_valid=1; state_out=buf, held stable until out_ready=1.
  - On out_valid&&out_ready: out_valid falls at the next edge and the FSM returns to IDLE.
- Latency, accept edge T to out_valid:
  - skip_mix=1: out_valid high in cycle T+1.
  - skip_mix=0: out_valid high in cycle T+5+MIX_PIPE.
- Throughput: one transaction in flight. in_ready=0 outside IDLE, so a new input is accepted no earlier than the cycle after the output handshake.
- Input signals are ignored outside IDLE. skip_mix changing mid-transaction has no effect.
- state_out changes only on the edge entering DONE; it is otherwise held, including after the handshake until the next DONE.
- All outputs are registered except in_ready, busy and col_to_mix, which are decoded from FSM state and counters.
- No arithmetic beyond XOR. Counters are 2-bit plus a pipeline-delay counter sized for MIX_PIPE.

Test Plan:
Benches connect the real column helper, with MIX_PIPE registers inserted in the helper path.
- Mix path, MIX_PIPE=0:
  - Stimulus: rkey=0, state_in=8e4da1bc_9fdc589d_01010101_d5d5d7d6, skip_mix=0.
  - Response: state_out=db135345_f20a225c_01010101_d4d4d4d5, out_valid exactly 5 cycles after accept, col_to_mix sequence 8e4da1bc, 9fdc589d, 01010101, d5d5d7d6.
- Key XOR plus mix:
  - Stimulus: state_in=ffffffff_..._ff, rkey=71b25e43_6023a762_fefefefe_2a2a2829.
  - Response: same state_out as the previous case.
- Skip path:
  - Stimulus: skip_mix=1, state_in=00112233_44556677_8899aabb_ccddeeff, rkey=0f0f0f0f_0f0f0f0f_0f0f0f0f_0f0f0f0f.
  - Response: state_out=0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0, out_valid at T+1, col_to_mix stays 0.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles in DONE; pulse in_valid with new data meanwhile.
  - Response: state_out stable, in_ready=0, new data ignored. After the out_ready pulse: IDLE, then the next accept proceeds normally.
- Pipelined helper:
  - Stimulus: MIX_PIPE=2 with vector 1.
  - Response: identical state_out, out_valid at T+7.
- Reset mid-operation:
  - Stimulus: assert rst during MIX, cycle T+2.
  - Response: next cycle is IDLE with out_valid=0, state_out=0, in_ray in_ready=1, and no spurious out_valid afterward.
